pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
//
// PURPOSE
//   Output stage driven by the SPI register file.
//   Consumes en_out[15:0], en_pwm_mode[15:0] and pwm_duty_cycle[7:0], and drives 16 registered outputs.
//   Each output is in one of three modes: off, static high, or PWM at a single shared duty cycle.
//   The duty cycle is double-buffered so that PWM edges never glitch when the value changes mid-period.
//
// PARAMETERS
//   PRESCALE  13  clk cycles per PWM count step (>=1). Period = 256*PRESCALE clk (3328 by default, ~3 kHz at 10 MHz).
//
// PORTS
//   clk             in   1   system clock; all logic in this single domain
//   rst_n           in   1   asynchronous, active-low reset
//   en_out          in   16  per-output enable (1 = output active)
//   en_pwm_mode     in   16  per-output mode (1 = PWM, 0 = static high when enabled)
//   pwm_duty_cycle  in   8   shared duty value; 0x00 = 0%, 0xFF = 100%
//   pwm_out         out  16  registered outputs; [7:0] map to uo_out, [15:8] map to uio_out
//   period_start    out  1   one-clk pulse in the first cycle of every PWM period
//
// BEHAVIOUR
//   Reset values (async assert, sync release):
//   - div_cnt=0, pwm_cnt=0, duty_shadow=0x00, pwm_out=16'h0000, period_start=0.
//   Prescaler:
//   - Width is max(1,$clog2(PRESCALE)).
//   - tick = (div_cnt==PRESCALE-1). On tick, div_cnt<=0; otherwise div_cnt<=div_cnt+1.
//   - When PRESCALE==1, tick is constantly 1.
//   PWM counter:
//   - 8 bits, pwm_cnt<=pwm_cnt+1 on tick; it wraps 255->0 naturally.
//   Period wrap:
//   - wrap = tick && pwm_cnt==8'hFF.
//   - On wrap, duty_shadow<=pwm_duty_cycle and period_start<=1. In all other cycles period_start<=0.
//   - period_start is therefore high exactly in the clk where pwm_cnt first reads 0.
//   - pwm_duty_cycle is sampled only on wrap. Changes mid-period take effect at the next period start.
//   - The first period after reset always runs at duty 0x00.
//   PWM level (combinational):
//   - level = (duty_shadow==8'hFF) ? 1 : (pwm_cnt < duty_shadow).
//   - Resulting high time per period is duty_shadow*PRESCALE clk, except 0xFF, which gives 100% (no low pulse).
//   - 0x00 gives constant low.
//   Output register, updated every clk:
//   - pwm_out[i] <= en_out[i] & (en_pwm_mode[i] ? level : 1'b1).
//   - Latency is 1 clk from an en_out/en_pwm_mode change to pwm_out.
//   - Latency is 1 clk from a pwm_cnt/duty_shadow change to pwm_out.
//   - en_out/en_pwm_mode are not shadowed: mode changes apply immediately, mid-period.
//   Simultaneous events:
//   - A duty change arriving in the same clk as wrap is captured; the new value is used from that period on.
//   Reset mid-period:
//   - All state returns to reset values immediately. pwm_out goes low asynchronously.
//   - The counter restarts at 0 and duty_shadow=0 until the first wrap.
//   Inputs:
//   - Inputs are already synchronous to clk, because the SPI stage registers them. No synchronizers are required.
//
// TESTING  (PRESCALE=13)
//   1. Reset, then en_out=16'h0001, en_pwm_mode=0 -> pwm_out=16'h0001 one clk later and steady; other bits stay 0.
//   2. en_out=16'h00FF, en_pwm_mode=16'h00FF, duty=0x80 -> from the 2nd period_start, pwm_out[7:0] is high for 1664 clk and low for 1664 clk; period is 3328 clk.
//   3. duty=0x00 -> PWM outputs constant 0. duty=0xFF -> PWM outputs constant 1 across a full period, with no low glitch at the wrap.
//   4. duty 0x40 written mid-period while 0xC0 is active -> the current period completes with high=2496 clk; the next period has high=832 clk.
//   5. en_pwm_mode toggled 1->0 on an enabled output while level=0 -> output goes high the next clk, without waiting for a period boundary.
//   6. Assert rst_n low mid-period with outputs high -> pwm_out=0 immediately. After release, period_start fires first at clk 3328 and pwm_out stays low for that first period.

Source files
------------

// File: rtl/pwm_peripheral.sv
// ----------------------------------------------------------------------------
// pwm_peripheral
//
// Output stage behind the SPI register file. Each of the 16 outputs is off,
// static high, or PWM at one shared duty cycle. The duty value is copied into
// a shadow register only at the period wrap, so a mid-period write never
// produces a truncated or extra pulse.
//
// Ports
//   clk             system clock (single domain)
//   rst_n           asynchronous, active-low reset (synchronous release upstream)
//   en_out          per-output enable, 1 = output active
//   en_pwm_mode     per-output mode, 1 = PWM, 0 = static high when enabled
//   pwm_duty_cycle  shared duty, 0x00 = 0 %, 0xFF = 100 %
//   pwm_out         registered outputs ([7:0] -> uo_out, [15:8] -> uio_out)
//   period_start    one-clk pulse in the first cycle of every PWM period
//
// Parameter
//   PRESCALE        clk cycles per PWM count step (>= 1); period = 256*PRESCALE
// ----------------------------------------------------------------------------
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] en_out,
  input  logic [15:0] en_pwm_mode,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  // A one-bit divider is kept for PRESCALE==1; it then stays at 0 and the
  // compare below makes tick constantly 1.
  localparam int unsigned     DIV_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_shadow_q, duty_shadow_d;
  logic [15:0]      pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;

  logic tick_s;
  logic wrap_s;
  logic level_s;

  // Prescaler, PWM counter and duty shadow next-state logic.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    pwm_cnt_d     = pwm_cnt_q;
    duty_shadow_d = duty_shadow_q;

    tick_s = (div_cnt_q == DIV_MAX);
    wrap_s = tick_s && (pwm_cnt_q == 8'hFF);

    if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      pwm_cnt_d = pwm_cnt_q + 8'd1;   // natural 255 -> 0 wrap
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      pwm_cnt_d = pwm_cnt_q;
    end

    // The new duty is captured even if it changes in the very wrap cycle.
    if (wrap_s) begin
      duty_shadow_d = pwm_duty_cycle;
    end else begin
      duty_shadow_d = duty_shadow_q;
    end

    period_start_d = wrap_s;
  end

  // PWM level and per-output mode selection.
  always_comb begin
    level_s   = 1'b0;
    pwm_out_d = 16'h0000;

    // 0xFF is forced to a solid high so there is no one-step low pulse at 255.
    if (duty_shadow_q == 8'hFF) begin
      level_s = 1'b1;
    end else begin
      level_s = (pwm_cnt_q < duty_shadow_q);
    end

    // Mode bits are not shadowed: they take effect on the next clk.
    pwm_out_d = en_out & ((en_pwm_mode & {16{level_s}}) | ~en_pwm_mode);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q      <= {DIV_W{1'b0}};
      pwm_cnt_q      <= 8'h00;
      duty_shadow_q  <= 8'h00;
      pwm_out_q      <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// ----------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Self-checking bench for pwm_peripheral with PRESCALE=13. The reference
// model derives everything from the number of clk edges since reset release:
// the count step is edges/PRESCALE mod 256, a period boundary is every
// 256*PRESCALE edges, and the duty in force is whatever was on the input at
// the most recent boundary.
// ----------------------------------------------------------------------------
module tb_pwm_peripheral;

  localparam int P      = 13;
  localparam int PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm_mode;
  logic [7:0]  duty;
  logic [15:0] pwm_out;
  logic        period_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_k;        // clk edges since reset release
  logic [7:0]  m_duty;     // duty in force for the current period
  logic        m_level;    // PWM level after the latest edge
  logic [15:0] m_out;
  logic        m_ps;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_out         (en_out),
    .en_pwm_mode    (en_pwm_mode),
    .pwm_duty_cycle (duty),
    .pwm_out        (pwm_out),
    .period_start   (period_start)
  );

  task automatic model_reset();
    m_k     = 0;
    m_duty  = 8'h00;
    m_level = 1'b0;
    m_out   = 16'h0000;
    m_ps    = 1'b0;
  endtask

  // Advance one clk: update the model from the inputs seen at the edge and
  // compare both outputs 1 time unit later.
  task automatic step();
    int step_idx;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      if (!en_out[i])          m_out[i] = 1'b0;
      else if (en_pwm_mode[i]) m_out[i] = m_level;
      else                     m_out[i] = 1'b1;
    end
    m_k  = m_k + 1;
    m_ps = ((m_k % PERIOD) == 0);
    if (m_ps) m_duty = duty;
    step_idx = int'((m_k / P) % 256);
    m_level  = (m_duty == 8'hFF) || (step_idx < int'(m_duty));
    #1;
    n_checks++;
    if (pwm_out !== m_out) begin
      n_fail++;
      $display("FAIL pwm_out edge %0d: got %h expected %h", m_k, pwm_out, m_out);
    end
    n_checks++;
    if (period_start !== m_ps) begin
      n_fail++;
      $display("FAIL period_start edge %0d: got %b expected %b", m_k, period_start, m_ps);
    end
  endtask

  // Step until the DUT pulses period_start, within one period plus margin.
  task automatic wait_ps(output int cycles);
    cycles = 0;
    for (int i = 0; i < PERIOD + 16; i++) begin
      step();
      cycles++;
      if (period_start === 1'b1) break;
    end
    n_checks++;
    if (period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ps timeout: got no pulse after %0d clk, required one within %0d", cycles, PERIOD + 16);
    end
  endtask

  // Count high cycles of one output over the PERIOD clks after a pulse,
  // optionally rewriting the duty input partway through.
  task automatic measure_high(input int bit_idx, input int change_at,
                              input logic [7:0] new_duty, output int highs);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == change_at) duty = new_duty;
      step();
      if (pwm_out[bit_idx] === 1'b1) highs++;
    end
    // The last edge of the window is the next period boundary.
    n_checks++;
    if (period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL period_length: got period_start=%b after %0d clk, required 1", period_start, PERIOD);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    en_out      = 16'h0000;
    en_pwm_mode = 16'h0000;
    duty        = 8'h00;
    model_reset();
    #1;
    n_checks++;
    if (pwm_out !== 16'h0000 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got pwm_out=%h period_start=%b, required 0000/0", pwm_out, period_start);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_static_high();
    en_out      = 16'h0001;
    en_pwm_mode = 16'h0000;
    step();
    n_checks++;
    if (pwm_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL static_high: got %h required 0001", pwm_out);
    end
    repeat (20) step();
  endtask

  task automatic test_pwm_half();
    int c, h;
    en_out      = 16'h00FF;
    en_pwm_mode = 16'h00FF;
    duty        = 8'h80;
    wait_ps(c);
    measure_high(0, -1, 8'h80, h);
    n_checks++;
    if (h != 128 * P) begin
      n_fail++;
      $display("FAIL pwm_half_high: got %0d clk high, required %0d", h, 128 * P);
    end
    measure_high(7, -1, 8'h80, h);
    n_checks++;
    if (PERIOD - h != 128 * P) begin
      n_fail++;
      $display("FAIL pwm_half_low: got %0d clk low, required %0d", PERIOD - h, 128 * P);
    end
  endtask

  task automatic test_duty_extremes();
    int c, h;
    duty = 8'h00;
    wait_ps(c);
    measure_high(3, -1, 8'h00, h);
    n_checks++;
    if (h != 0) begin
      n_fail++;
      $display("FAIL duty_zero: got %0d clk high, required 0", h);
    end
    duty = 8'hFF;
    wait_ps(c);
    measure_high(3, -1, 8'hFF, h);
    n_checks++;
    if (h != PERIOD) begin
      n_fail++;
      $display("FAIL duty_full: got %0d clk high, required %0d", h, PERIOD);
    end
    // Window above ends on the wrap edge; the output must still be high.
    step();
    n_checks++;
    if (pwm_out[7:0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL duty_full_wrap: got %h after wrap, required ff", pwm_out[7:0]);
    end
  endtask

  task automatic test_midperiod_change();
    int c, h;
    duty = 8'hC0;
    wait_ps(c);
    measure_high(0, 1000, 8'h40, h);
    n_checks++;
    if (h != 192 * P) begin
      n_fail++;
      $display("FAIL midperiod_current: got %0d clk high, required %0d", h, 192 * P);
    end
    measure_high(0, -1, 8'h40, h);
    n_checks++;
    if (h != 64 * P) begin
      n_fail++;
      $display("FAIL midperiod_next: got %0d clk high, required %0d", h, 64 * P);
    end
  endtask

  task automatic test_mode_toggle();
    int c;
    duty = 8'h40;
    wait_ps(c);
    repeat (64 * P + 20) step();
    n_checks++;
    if (pwm_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_toggle_pre: got %b, required 0", pwm_out[0]);
    end
    en_pwm_mode[0] = 1'b0;
    step();
    n_checks++;
    if (pwm_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_toggle_post: got %b, required 1", pwm_out[0]);
    end
    repeat (30) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * PERIOD; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        en_out      = 16'($urandom);
        en_pwm_mode = 16'($urandom);
      end
      // Duty changes either at random or exactly on the wrap edge.
      if ($urandom_range(0, 699) == 0 || ((m_k + 1) % PERIOD) == 0)
        duty = 8'($urandom);
      step();
    end
  endtask

  task automatic test_reset_mid_period();
    int c, cycles, highs;
    en_out      = 16'hFFFF;
    en_pwm_mode = 16'hFFFF;
    duty        = 8'hFF;
    wait_ps(c);
    repeat (500) step();
    n_checks++;
    if (pwm_out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_pre: got %h required ffff", pwm_out);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pwm_out !== 16'h0000 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got pwm_out=%h period_start=%b, required 0000/0", pwm_out, period_start);
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cycles = 0;
    highs  = 0;
    for (int i = 0; i < PERIOD + 16; i++) begin
      step();
      cycles++;
      if (pwm_out !== 16'h0000) highs++;
      if (period_start === 1'b1) break;
    end
    n_checks++;
    if (cycles != PERIOD || period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_ps: got pulse at clk %0d (ps=%b), required %0d", cycles, period_start, PERIOD);
    end
    n_checks++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL reset_first_period: got %0d clk with outputs high, required 0", highs);
    end
    repeat (200) step();
  endtask

  initial begin
    test_reset();
    test_static_high();
    test_pwm_half();
    test_duty_extremes();
    test_midperiod_change();
    test_mode_toggle();
    test_random();
    test_reset_mid_period();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
